// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes and default baud generator constants.
package uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Accumulator tick generator: 50 MHz * 151 / 2^12 ~= 16 x 115200 baud.
   localparam int BAUD_INC = 151;
   localparam int BAUD_N   = 12;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with configurable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic CLK50MHZ,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 default, LSB first) driven by an external tick enable.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 4
) (
   input  logic                 CLK50MHZ,
   input  logic                 RST,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int BIDX_W = $clog2(DATA_BITS) + 1;
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
       (1 << CNT_W) < OVERSAMPLE) begin : g_bad_param
      $error("uart_rx: illegal DATA_BITS/OVERSAMPLE/CNT_W combination");
   end

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_DATA  = ST_DATA,
      S_STOP  = ST_STOP
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [BIDX_W-1:0]      bitidx;
   logic [DATA_BITS-1:0]   shreg;
   logic                   rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .d        (rx),
      .q        (rx_s)
   );

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bitidx    <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (!rx_s) begin
                     state <= S_START;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               // Re-check the line at mid start bit to reject short glitches.
               S_START: begin
                  if (cnt == HALF_LAST) begin
                     cnt    <= '0;
                     bitidx <= '0;
                     if (!rx_s) begin
                        state <= S_DATA;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (cnt == FULL_LAST) begin
                     cnt    <= '0;
                     shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
                     bitidx <= bitidx + 1'b1;
                     if (bitidx == LAST_BIT) state <= S_STOP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               // Leave at mid stop bit so a start edge right after it is caught.
               S_STOP: begin
                  if (cnt == FULL_LAST) begin
                     cnt   <= '0;
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     if (rx_s) begin
                        data  <= shreg;
                        valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames in, expected strobes queued, monitor compares.
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   logic       CLK50MHZ = 1'b0;
   logic       RST = 1'b1;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, busy;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .CNT_W(4)) dut (
      .CLK50MHZ  (CLK50MHZ),
      .RST       (RST),
      .tick      (tick),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #10 CLK50MHZ = ~CLK50MHZ;

   // tmode 0: tick every 4 clk; tmode 1: accumulator generator at 16 x 115200.
   int                tmode = 0;
   int                div = 0;
   logic [BAUD_N-1:0] acc = '0;
   always @(posedge CLK50MHZ) begin
      if (tmode == 0) begin
         div  <= (div == 3) ? 0 : div + 1;
         tick <= (div == 3);
      end else begin
         {tick, acc} <= {1'b0, acc} + (BAUD_N+1)'(BAUD_INC);
      end
   end

   typedef struct {
      bit         ferr;
      logic [7:0] d;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   real        bit_ns = 1280.0;
   logic [7:0] model_data = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] d, input bit stop, input int idle_bits);
      exp_t e;
      e.ferr = !stop;
      e.d    = d;
      q.push_back(e);
      if (stop) model_data = d;
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bit_ns);
      end
      rx = stop;
      #(bit_ns);
      rx = 1'b1;
      if (stop) begin
         @(negedge CLK50MHZ);
         chk("busy_after_frame", {31'b0, busy}, 32'd0);
      end
      repeat (idle_bits) #(bit_ns);
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   logic [7:0] exp_last = 8'h00;
   bit         prev_strobe = 1'b0;
   always @(negedge CLK50MHZ) begin
      exp_t e;
      if (RST) begin
         exp_last    = 8'h00;
         prev_strobe = 1'b0;
      end else begin
         if (valid || frame_err) begin
            chk("strobe_exclusive", {31'b0, valid & frame_err}, 32'd0);
            chk("strobe_width", {31'b0, prev_strobe}, 32'd0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%0h", valid, frame_err, data);
            end else begin
               e = q.pop_front();
               chk("strobe_kind", {31'b0, frame_err}, {31'b0, e.ferr});
               if (!e.ferr) exp_last = e.d;
               chk("data", {24'b0, data}, {24'b0, exp_last});
            end
         end
         prev_strobe = valid | frame_err;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] p55;
      repeat (5) @(negedge CLK50MHZ);
      chk("rst_data", {24'b0, data}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      RST = 1'b0;
      repeat (10) @(negedge CLK50MHZ);
      #7;

      send(8'hA5, 1'b1, 1);

      // Start glitch: ~3 ticks low, then high.
      rx = 1'b0;
      #200;
      @(negedge CLK50MHZ);
      chk("glitch_busy_high", {31'b0, busy}, 32'd1);
      rx = 1'b1;
      #1500;
      @(negedge CLK50MHZ);
      chk("glitch_busy_low", {31'b0, busy}, 32'd0);
      chk("glitch_data_hold", {24'b0, data}, {24'b0, model_data});

      send(8'h3C, 1'b0, 2);
      send(8'h00, 1'b1, 0);
      send(8'hFF, 1'b1, 1);

      // Abort 0x55 during data bit 3 with a reset pulse.
      p55 = 8'h55;
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 3; i++) begin
         rx = p55[i];
         #(bit_ns);
      end
      rx = p55[3];
      #(bit_ns / 2);
      @(negedge CLK50MHZ);
      RST = 1'b1;
      repeat (2) @(negedge CLK50MHZ);
      RST = 1'b0;
      model_data = 8'h00;
      chk("midrst_data", {24'b0, data}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      rx = 1'b1;
      #(3 * bit_ns);
      send(8'h81, 1'b1, 1);

      for (int n = 0; n < 30; n++) begin
         b = 8'($urandom_range(255));
         if ($urandom_range(7) == 0) send(b, 1'b0, 2);
         else send(b, 1'b1, $urandom_range(2));
      end
      #(2 * bit_ns);

      // Real generator, line at 115200 baud +/-2%.
      tmode = 1;
      for (int n = 0; n < 6; n++) begin
         bit_ns = (n % 2 == 0) ? (1.0e9 / (115200.0 * 1.02)) : (1.0e9 / (115200.0 * 0.98));
         #(bit_ns);
         if (n == 0) b = 8'h00;
         else if (n == 1) b = 8'hFF;
         else b = 8'($urandom_range(255));
         send(b, 1'b1, 1);
      end

      repeat (50) @(negedge CLK50MHZ);
      chk("pending_expectations", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: 8N1 by default, LSB first, 16x oversampling.
- Consumes the 1-cycle enable pulse from the existing baud-rate tick generator, which the parent instantiates, and deserializes the rx line into parallel bytes.
- Emits a 1-cycle strobe per good byte and a framing-error strobe per bad stop bit.
- Sits between the board RS-232 pin and the byte consumer (command parser or FIFO).

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, tick pulses per bit period; must be even and >= 4.
- CNT_W, 4, width of the oversample counter; must satisfy 2^CNT_W >= OVERSAMPLE.

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz.
- RST  in  1  reset; synchronous, active-high; clock CLK50MHZ.
- tick  in  1  oversample enable, 1-cycle pulse at OVERSAMPLE x baud. For 115200 baud: generator INC=151, N=12.
- rx  in  1  asynchronous serial input; idle high.
- data  out  DATA_BITS  last correctly framed byte; holds until the next good frame.
- valid  out  1  1-cycle pulse; data is new on this cycle.
- frame_err  out  1  1-cycle pulse; stop bit was sampled low.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Input sync: rx passes through a 2-FF synchronizer (rx_s), preset to 1 on reset. All decisions use rx_s.
- Reset values:
  - outputs: data=0, valid=0, frame_err=0, busy=0.
  - internal: state=IDLE, cnt=0, bitidx=0, shreg=0.
- RST mid-frame aborts the frame immediately. No strobe is produced for the partial byte.
- State and counter advance only on cycles with tick=1. tick=0 freezes everything except the synchronizer and the strobe clearing.
- States:
  - IDLE: on tick with rx_s=0, go to START with cnt=0.
  - START: on tick, cnt++. When cnt reaches OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA with cnt=0, bitidx=0.
    - rx_s=1: glitch; return to IDLE with no strobe.
  - DATA: on tick, cnt++. When cnt reaches OVERSAMPLE-1 (mid data bit):
    - shreg <= {rx_s, shreg[DATA_BITS-1:1]}, i.e. LSB first.
    - cnt=0, bitidx++.
    - After bit DATA_BITS-1 is sampled, go to STOP.
  - STOP: on tick, cnt++. When cnt reaches OVERSAMPLE-1, sample rx_s and return to IDLE:
    - rx_s=1: data <= shreg; valid=1 for exactly one cycle.
    - rx_s=0: frame_err=1 for exactly one cycle; data unchanged.
- Re-arm: the return to IDLE happens at mid stop bit, so a start edge immediately after the stop bit is caught. Back-to-back frames need no idle gap.
- Break condition (rx held low): produces frame_err once per frame period while the line stays low.
- Latency: valid rises on the clock edge following the tick that samples the stop bit. Nominal ~9.5 bit periods after the start edge, +2 clk of synchronizer delay.
- valid and frame_err are never high together. Neither can occur while busy=1 except on the exit edge from STOP.
- Counters are plain binary and wrap only via explicit clears. bitidx width is clog2(DATA_BITS)+1.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_STOP;
  - the default baud constants INC=151, N=12 for 115200 at 50 MHz.
- One natural sub-module: sync_2ff, a 1-bit synchronizer with a reset value parameter. It is reusable by the future transmitter's CTS input.
- The tick source is not instantiated inside uart_rx.

Test Plan:
- Good byte: tick every 4 clk, OVERSAMPLE=16, send 0xA5 with stop=1 → data=0xA5, a single valid pulse, frame_err stays 0, busy drops after the stop-bit sample.
- Start glitch: rx low for 3 ticks then high → busy pulses and returns to IDLE at mid-start; no valid, no frame_err; data still holds its prior value.
- Framing error: send 0x3C with stop=0 → one frame_err pulse, no valid; data keeps the previous 0xA5.
- Back-to-back frames: 0x00 then 0xFF with no idle between → two valid pulses, data=0x00 then 0xFF; each pulse is 1 cycle wide.
- Reset mid-frame: assert RST during data bit 3 of 0x55, then send 0x81 → no strobe for the aborted frame; data=0x81 with one valid.
- Tick jitter: tick driven by the real generator (INC=151, N=12) at 115200 baud ±2% → bytes 0x00..0xFF received error-free.
